any1_rob: RTL and testbench

- Parametrised reorder buffer for the ANY-1 pipeline, built around the shared reorder-entry record (v, cmt, Rt, res, cause).
- Allocates a rid per decoded instruction and accepts out-of-order execute/memory writebacks.
- Retires up to NCMT entries per cycle in program order.
- Raises a precise exception on the head entry and supports partial flush for branch mispredicts.

---
 rtl/any1_rob_pkg.sv | 19 +
 rtl/any1_rob_if.sv | 40 ++++
 rtl/any1_rob_cmtsel.sv | 20 ++
 rtl/any1_rob.sv | 123 ++++++++++++
 tb/tb_any1_rob.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/any1_rob_pkg.sv
// Shared reorder-buffer types for the ANY-1 pipeline: fault causes, entry status
// record and the commit-readiness helper used by the lane selector.
package any1_rob_pkg;

    localparam logic [7:0] FLT_NONE = 8'h00;

    // Width-independent slice of a reorder entry; the full record carries a
    // WID-wide result and is declared where WID is known.
    typedef struct packed {
        logic       v;
        logic       cmt;
        logic [7:0] cause;
    } sEntryStat;

    function automatic logic cmt_ok(sEntryStat s);
        return s.v && s.cmt && (s.cause == FLT_NONE);
    endfunction

endpackage

// File: rtl/any1_rob_if.sv
// Pipeline <-> reorder buffer bundle: allocate, writeback, flush, commit and exception.
interface any1_rob_if #(
    parameter int DEPTH = 16,
    parameter int WID   = 64,
    parameter int NCMT  = 2
);
    localparam int RIDW = $clog2(DEPTH);

    logic                      alloc_i;
    logic [5:0]                alloc_Rt_i;
    logic                      alloc_rdy_o;
    logic [RIDW-1:0]           alloc_rid_o;
    logic                      wb_v_i;
    logic [RIDW-1:0]           wb_rid_i;
    logic [WID-1:0]            wb_res_i;
    logic [7:0]                wb_cause_i;
    logic                      flush_i;
    logic [RIDW-1:0]           flush_rid_i;
    logic [NCMT-1:0]           cmt_v_o;
    logic [NCMT-1:0][5:0]      cmt_Rt_o;
    logic [NCMT-1:0][WID-1:0]  cmt_res_o;
    logic                      exc_o;
    logic [7:0]                exc_cause_o;
    logic [RIDW-1:0]           exc_rid_o;
    logic                      empty_o;
    logic                      full_o;

    modport master (
        output alloc_i, alloc_Rt_i, wb_v_i, wb_rid_i, wb_res_i, wb_cause_i, flush_i, flush_rid_i,
        input  alloc_rdy_o, alloc_rid_o, cmt_v_o, cmt_Rt_o, cmt_res_o,
               exc_o, exc_cause_o, exc_rid_o, empty_o, full_o
    );

    modport slave (
        input  alloc_i, alloc_Rt_i, wb_v_i, wb_rid_i, wb_res_i, wb_cause_i, flush_i, flush_rid_i,
        output alloc_rdy_o, alloc_rid_o, cmt_v_o, cmt_Rt_o, cmt_res_o,
               exc_o, exc_cause_o, exc_rid_o, empty_o, full_o
    );

endinterface

// File: rtl/any1_rob_cmtsel.sv
// Commit lane selector: in-order ready mask over head..head+NCMT-1 and head-fault detect.
module any1_rob_cmtsel import any1_rob_pkg::*; #(
    parameter int NCMT = 2
) (
    input  sEntryStat [NCMT-1:0] stat,
    output logic      [NCMT-1:0] sel,
    output logic                 exc
);

    // A lane commits only if every older lane commits too, so a fault in a
    // later lane simply stalls until it becomes the head.
    always_comb begin
        sel    = '0;
        sel[0] = cmt_ok(stat[0]);
        for (int k = 1; k < NCMT; k++)
            sel[k] = sel[k-1] && cmt_ok(stat[k]);
        exc = stat[0].v && stat[0].cmt && (stat[0].cause != FLT_NONE);
    end

endmodule

// File: rtl/any1_rob.sv
// ANY-1 reorder buffer: rid allocation, out-of-order writeback, in-order
// multi-lane retire, precise head exception and partial mispredict flush.
module any1_rob import any1_rob_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int WID   = 64,
    parameter int NCMT  = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    any1_rob_if.slave rob
);
    localparam int RIDW = $clog2(DEPTH);

    typedef struct packed {
        logic           v;
        logic           cmt;
        logic [5:0]     Rt;
        logic [WID-1:0] res;
        logic [7:0]     cause;
    } sReorderEntry;

    typedef struct packed {
        logic           v;
        logic [5:0]     Rt;
        logic [WID-1:0] res;
    } sRobCommit;

    sReorderEntry              ent [DEPTH];
    logic [RIDW-1:0]           head, tail, foff;
    logic [RIDW:0]             cnt, surv, ncmt;
    logic [RIDW-1:0]           lrid [NCMT];
    sEntryStat [NCMT-1:0]      lstat;
    sRobCommit [NCMT-1:0]      cnxt;
    logic [NCMT-1:0]           lsel, lmask;
    logic                      exc_det, acc;

    always_comb begin
        for (int k = 0; k < NCMT; k++) begin
            lrid[k]  = head + RIDW'(k);
            lstat[k] = '{v: ent[lrid[k]].v, cmt: ent[lrid[k]].cmt, cause: ent[lrid[k]].cause};
        end
    end

    any1_rob_cmtsel #(.NCMT(NCMT)) u_cmtsel (
        .stat (lstat),
        .sel  (lsel),
        .exc  (exc_det)
    );

    // Entries surviving a flush are head..flush_rid inclusive; lanes past the
    // mispredicted branch must not retire in the flush cycle.
    always_comb begin
        foff = rob.flush_rid_i - head;
        surv = {1'b0, foff} + (RIDW+1)'(1);
        ncmt = '0;
        for (int k = 0; k < NCMT; k++) begin
            lmask[k] = lsel[k] && (!rob.flush_i || ((RIDW+1)'(k) < surv));
            ncmt     = ncmt + (RIDW+1)'(lmask[k]);
            cnxt[k]  = '{v:   lmask[k],
                         Rt:  lmask[k] ? ent[lrid[k]].Rt  : 6'd0,
                         res: lmask[k] ? ent[lrid[k]].res : {WID{1'b0}}};
        end
    end

    assign acc             = rob.alloc_i && rob.alloc_rdy_o && !rob.flush_i && !exc_det;
    assign rob.alloc_rdy_o = (cnt != (RIDW+1)'(DEPTH));
    assign rob.full_o      = (cnt == (RIDW+1)'(DEPTH));
    assign rob.empty_o     = (cnt == '0);
    assign rob.alloc_rid_o = tail;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head            <= '0;
            tail            <= '0;
            cnt             <= '0;
            rob.cmt_v_o     <= '0;
            rob.cmt_Rt_o    <= '0;
            rob.cmt_res_o   <= '0;
            rob.exc_o       <= 1'b0;
            rob.exc_cause_o <= '0;
            rob.exc_rid_o   <= '0;
        end else begin
            for (int k = 0; k < NCMT; k++) begin
                rob.cmt_v_o[k]   <= cnxt[k].v;
                rob.cmt_Rt_o[k]  <= cnxt[k].Rt;
                rob.cmt_res_o[k] <= cnxt[k].res;
            end
            rob.exc_o <= exc_det;
            if (exc_det) begin
                rob.exc_cause_o <= ent[head].cause;
                rob.exc_rid_o   <= head;
                for (int i = 0; i < DEPTH; i++) ent[i].v <= 1'b0;
                head <= head + RIDW'(1);
                tail <= head + RIDW'(1);
                cnt  <= '0;
            end else begin
                if (rob.wb_v_i && ent[rob.wb_rid_i].v) begin
                    ent[rob.wb_rid_i].cmt   <= 1'b1;
                    ent[rob.wb_rid_i].res   <= rob.wb_res_i;
                    ent[rob.wb_rid_i].cause <= rob.wb_cause_i;
                end
                for (int k = 0; k < NCMT; k++)
                    if (lmask[k]) ent[lrid[k]].v <= 1'b0;
                head <= head + ncmt[RIDW-1:0];
                if (rob.flush_i) begin
                    for (int i = 0; i < DEPTH; i++)
                        if (RIDW'(RIDW'(i) - head) > foff) ent[i].v <= 1'b0;
                    tail <= rob.flush_rid_i + RIDW'(1);
                    cnt  <= surv - ncmt;
                end else begin
                    if (acc) begin
                        ent[tail] <= '{v: 1'b1, cmt: 1'b0, Rt: rob.alloc_Rt_i,
                                       res: {WID{1'b0}}, cause: FLT_NONE};
                        tail <= tail + RIDW'(1);
                    end
                    cnt <= cnt + (RIDW+1)'(acc) - ncmt;
                end
            end
        end
    end

endmodule

// File: tb/tb_any1_rob.sv
// Bench for any1_rob: directed scenarios plus random traffic against a queue-based model.
module tb_any1_rob;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    any1_rob_if #(.DEPTH(16), .WID(64), .NCMT(2)) rif ();
    any1_rob_if #(.DEPTH(16), .WID(64), .NCMT(1)) rif1 ();

    any1_rob #(.DEPTH(16), .WID(64), .NCMT(2)) dut  (.clk_i(clk), .rst_ni(rst_n), .rob(rif.slave));
    any1_rob #(.DEPTH(16), .WID(64), .NCMT(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .rob(rif1.slave));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: program-order queue of live rids plus per-rid payload.
    int          q[$];
    int          mtail;
    logic [5:0]  mRt   [16];
    logic [63:0] mres  [16];
    logic [7:0]  mcause[16];
    bit          mdone [16];
    logic [1:0]  e_v;
    logic [5:0]  e_Rt  [2];
    logic [63:0] e_res [2];
    logic        e_exc;
    logic [7:0]  e_cause;
    logic [3:0]  e_rid;

    task automatic model_step();
        int n, idx, surv, sz0;
        bit ex, inq;
        if (!rst_n) begin
            q.delete(); mtail = 0; e_v = '0; e_exc = 0; e_cause = '0; e_rid = '0;
            return;
        end
        sz0 = q.size();
        n = 0;
        for (int k = 0; k < 2; k++)
            if (k < q.size() && n == k && mdone[q[k]] && mcause[q[k]] == 8'h00) n++;
        ex = (q.size() > 0) && mdone[q[0]] && (mcause[q[0]] != 8'h00);
        if (rif.flush_i && !ex) begin
            idx = -1;
            for (int i = 0; i < q.size(); i++) if (q[i] == int'(rif.flush_rid_i)) idx = i;
            surv = idx + 1;
            if (n > surv) n = surv;
        end
        e_v = '0;
        for (int k = 0; k < n; k++) begin
            e_v[k] = 1'b1; e_Rt[k] = mRt[q[k]]; e_res[k] = mres[q[k]];
        end
        e_exc = ex;
        if (ex) begin e_cause = mcause[q[0]]; e_rid = 4'(q[0]); end
        inq = 0;
        foreach (q[i]) if (q[i] == int'(rif.wb_rid_i)) inq = 1;
        if (rif.wb_v_i && inq) begin
            mdone[rif.wb_rid_i] = 1; mres[rif.wb_rid_i] = rif.wb_res_i;
            mcause[rif.wb_rid_i] = rif.wb_cause_i;
        end
        if (ex) begin
            mtail = (q[0] + 1) % 16;
            q.delete();
        end else begin
            for (int k = 0; k < n; k++) void'(q.pop_front());
            if (rif.flush_i) begin
                while (q.size() > 0 && q[$] != int'(rif.flush_rid_i)) void'(q.pop_back());
                mtail = (int'(rif.flush_rid_i) + 1) % 16;
            end else if (rif.alloc_i && sz0 < 16) begin
                q.push_back(mtail); mRt[mtail] = rif.alloc_Rt_i; mdone[mtail] = 0;
                mtail = (mtail + 1) % 16;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rif.alloc_i = 0; rif.alloc_Rt_i = '0; rif.wb_v_i = 0; rif.wb_rid_i = '0;
        rif.wb_res_i = '0; rif.wb_cause_i = '0; rif.flush_i = 0; rif.flush_rid_i = '0;
        rif1.alloc_i = 0; rif1.alloc_Rt_i = '0; rif1.wb_v_i = 0; rif1.wb_rid_i = '0;
        rif1.wb_res_i = '0; rif1.wb_cause_i = '0; rif1.flush_i = 0; rif1.flush_rid_i = '0;
    endtask

    task automatic rst_pulse();
        idle(); rst_n = 0; tick(); rst_n = 1;
    endtask

    task automatic alloc_n(input int n, input int rt0);
        for (int i = 0; i < n; i++) begin
            rif.alloc_i = 1; rif.alloc_Rt_i = 6'(rt0 + i); tick();
        end
        rif.alloc_i = 0;
    endtask

    task automatic wb(input int rid, input logic [63:0] res, input logic [7:0] cause);
        rif.wb_v_i = 1; rif.wb_rid_i = 4'(rid); rif.wb_res_i = res; rif.wb_cause_i = cause;
        tick();
        rif.wb_v_i = 0;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0; tick(); tick(); rst_n = 1;
        n_chk++;
        if ({rif.cmt_v_o, rif.exc_o, rif.exc_cause_o, rif.exc_rid_o} !== 15'h0) begin
            n_fail++; $display("FAIL reset_cmt_exc got %h want 0", {rif.cmt_v_o, rif.exc_o, rif.exc_cause_o, rif.exc_rid_o});
        end
        n_chk++;
        if (rif.cmt_Rt_o !== 12'h0 || rif.cmt_res_o !== 128'h0) begin
            n_fail++; $display("FAIL reset_data got %h/%h want 0", rif.cmt_Rt_o, rif.cmt_res_o);
        end
        n_chk++;
        if ({rif.empty_o, rif.full_o, rif.alloc_rdy_o, rif.alloc_rid_o} !== 7'b1010000) begin
            n_fail++; $display("FAIL reset_status got %b want 1010000", {rif.empty_o, rif.full_o, rif.alloc_rdy_o, rif.alloc_rid_o});
        end
    endtask

    task automatic test_inorder();
        rst_pulse();
        alloc_n(3, 1);
        wb(2, 64'hA, 8'h00); wb(1, 64'hB, 8'h00); wb(0, 64'hC, 8'h00);
        n_chk++;
        if (rif.cmt_v_o !== 2'b00) begin n_fail++; $display("FAIL inorder_latency got %b want 00", rif.cmt_v_o); end
        tick();
        n_chk++;
        if ({rif.cmt_v_o, rif.cmt_Rt_o[0], rif.cmt_res_o[0], rif.cmt_Rt_o[1], rif.cmt_res_o[1]} !==
            {2'b11, 6'd1, 64'hC, 6'd2, 64'hB}) begin
            n_fail++; $display("FAIL inorder_pair got v=%b Rt=%0d/%0d res=%h/%h want 11 1/2 c/b",
                rif.cmt_v_o, rif.cmt_Rt_o[0], rif.cmt_Rt_o[1], rif.cmt_res_o[0], rif.cmt_res_o[1]);
        end
        tick();
        n_chk++;
        if ({rif.cmt_v_o, rif.cmt_Rt_o[0], rif.cmt_res_o[0], rif.empty_o} !== {2'b01, 6'd3, 64'hA, 1'b1}) begin
            n_fail++; $display("FAIL inorder_last got v=%b Rt=%0d res=%h empty=%b want 01 3 a 1",
                rif.cmt_v_o, rif.cmt_Rt_o[0], rif.cmt_res_o[0], rif.empty_o);
        end
    endtask

    task automatic test_fill_wrap();
        rst_pulse();
        alloc_n(16, 0);
        n_chk++;
        if ({rif.full_o, rif.alloc_rdy_o, rif.alloc_rid_o} !== 6'b100000) begin
            n_fail++; $display("FAIL fill_full got %b want 100000", {rif.full_o, rif.alloc_rdy_o, rif.alloc_rid_o});
        end
        alloc_n(1, 63);
        n_chk++;
        if ({rif.full_o, rif.alloc_rid_o} !== 5'b10000) begin
            n_fail++; $display("FAIL fill_overflow got %b want 10000", {rif.full_o, rif.alloc_rid_o});
        end
        wb(1, 64'h1, 8'h00); wb(0, 64'h0, 8'h00); tick();
        n_chk++;
        if ({rif.cmt_v_o, rif.full_o, rif.alloc_rid_o} !== 7'b1100000) begin
            n_fail++; $display("FAIL fill_commit2 got %b want 1100000", {rif.cmt_v_o, rif.full_o, rif.alloc_rid_o});
        end
        alloc_n(1, 50);
        n_chk++;
        if ({rif.full_o, rif.alloc_rid_o} !== 5'b00001) begin
            n_fail++; $display("FAIL fill_wrap1 got %b want 00001", {rif.full_o, rif.alloc_rid_o});
        end
        alloc_n(1, 51);
        n_chk++;
        if ({rif.full_o, rif.alloc_rid_o} !== 5'b10010) begin
            n_fail++; $display("FAIL fill_wrap2 got %b want 10010", {rif.full_o, rif.alloc_rid_o});
        end
    endtask

    task automatic test_exception();
        int seen;
        rst_pulse();
        alloc_n(4, 10);
        wb(0, 64'h11, 8'h00);
        wb(1, 64'h22, 8'h06);
        n_chk++;
        if ({rif.cmt_v_o, rif.cmt_Rt_o[0], rif.exc_o} !== {2'b01, 6'd10, 1'b0}) begin
            n_fail++; $display("FAIL exc_pre_commit got v=%b Rt=%0d exc=%b want 01 10 0", rif.cmt_v_o, rif.cmt_Rt_o[0], rif.exc_o);
        end
        tick();
        n_chk++;
        if ({rif.exc_o, rif.exc_cause_o, rif.exc_rid_o, rif.cmt_v_o, rif.empty_o} !== {1'b1, 8'h06, 4'd1, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL exc_raise got exc=%b cause=%h rid=%0d v=%b empty=%b want 1 06 1 00 1",
                rif.exc_o, rif.exc_cause_o, rif.exc_rid_o, rif.cmt_v_o, rif.empty_o);
        end
        seen = 0;
        wb(2, 64'h33, 8'h00); seen += int'(rif.cmt_v_o != 0) + int'(rif.exc_o);
        wb(3, 64'h44, 8'h00); seen += int'(rif.cmt_v_o != 0) + int'(rif.exc_o);
        tick();               seen += int'(rif.cmt_v_o != 0) + int'(rif.exc_o);
        tick();               seen += int'(rif.cmt_v_o != 0) + int'(rif.exc_o);
        n_chk++;
        if (seen != 0 || rif.alloc_rid_o !== 4'd2 || rif.exc_cause_o !== 8'h06) begin
            n_fail++; $display("FAIL exc_after got events=%0d rid=%0d cause=%h want 0 2 06", seen, rif.alloc_rid_o, rif.exc_cause_o);
        end
    endtask

    task automatic test_flush();
        int got[$];
        rst_pulse();
        alloc_n(6, 20);
        rif.flush_i = 1; rif.flush_rid_i = 4'd2; rif.alloc_i = 1; rif.alloc_Rt_i = 6'd33;
        tick();
        rif.flush_i = 0; rif.alloc_i = 0;
        n_chk++;
        if ({rif.alloc_rid_o, rif.empty_o, rif.full_o} !== {4'd3, 2'b00}) begin
            n_fail++; $display("FAIL flush_tail got rid=%0d empty=%b full=%b want 3 0 0", rif.alloc_rid_o, rif.empty_o, rif.full_o);
        end
        wb(4, 64'h99, 8'h00);
        alloc_n(12, 40);
        n_chk++;
        if (rif.full_o !== 1'b0) begin n_fail++; $display("FAIL flush_count15 got full=%b want 0", rif.full_o); end
        alloc_n(1, 52);
        n_chk++;
        if (rif.full_o !== 1'b1) begin n_fail++; $display("FAIL flush_count16 got full=%b want 1", rif.full_o); end
        for (int r = 0; r < 7; r++) begin
            if (r < 4) wb(r, 64'(r), 8'h00); else tick();
            for (int k = 0; k < 2; k++) if (rif.cmt_v_o[k]) got.push_back(int'(rif.cmt_Rt_o[k]));
        end
        n_chk++;
        if (got.size() != 4 || got[0] != 20 || got[2] != 22 || got[3] != 40) begin
            n_fail++; $display("FAIL flush_commits got n=%0d want 4 with Rt 20,21,22,40", got.size());
        end
    endtask

    task automatic test_reset_mid();
        rst_pulse();
        alloc_n(5, 5);
        wb(0, 64'h5, 8'h00);
        rst_n = 0; rif.wb_v_i = 1; rif.wb_rid_i = 4'd1; rif.wb_res_i = 64'h6;
        tick();
        rst_n = 1; rif.wb_v_i = 0;
        n_chk++;
        if ({rif.cmt_v_o, rif.exc_o, rif.empty_o, rif.full_o, rif.alloc_rid_o} !== {2'b00, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL rstmid_state got %b want 000100000", {rif.cmt_v_o, rif.exc_o, rif.empty_o, rif.full_o, rif.alloc_rid_o});
        end
        tick(); tick();
        n_chk++;
        if (rif.cmt_v_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_nocommit got %b want 00", rif.cmt_v_o); end
    endtask

    task automatic test_ncmt1();
        rst_pulse();
        rif1.alloc_i = 1; rif1.alloc_Rt_i = 6'd7; tick();
        rif1.alloc_Rt_i = 6'd8; tick();
        rif1.alloc_i = 0;
        rif1.wb_v_i = 1; rif1.wb_rid_i = 4'd1; rif1.wb_res_i = 64'h81; tick();
        rif1.wb_rid_i = 4'd0; rif1.wb_res_i = 64'h80; tick();
        rif1.wb_v_i = 0;
        tick();
        n_chk++;
        if ({rif1.cmt_v_o, rif1.cmt_Rt_o[0], rif1.cmt_res_o[0]} !== {1'b1, 6'd7, 64'h80}) begin
            n_fail++; $display("FAIL ncmt1_first got v=%b Rt=%0d res=%h want 1 7 80", rif1.cmt_v_o, rif1.cmt_Rt_o[0], rif1.cmt_res_o[0]);
        end
        tick();
        n_chk++;
        if ({rif1.cmt_v_o, rif1.cmt_Rt_o[0], rif1.cmt_res_o[0], rif1.empty_o} !== {1'b1, 6'd8, 64'h81, 1'b1}) begin
            n_fail++; $display("FAIL ncmt1_second got v=%b Rt=%0d res=%h empty=%b want 1 8 81 1",
                rif1.cmt_v_o, rif1.cmt_Rt_o[0], rif1.cmt_res_o[0], rif1.empty_o);
        end
        tick();
        n_chk++;
        if (rif1.cmt_v_o !== 1'b0) begin n_fail++; $display("FAIL ncmt1_idle got %b want 0", rif1.cmt_v_o); end
    endtask

    task automatic test_random();
        rst_pulse();
        for (int c = 0; c < 800; c++) begin
            rif.alloc_i    = 1'($urandom_range(0, 1));
            rif.alloc_Rt_i = 6'($urandom);
            rif.wb_v_i     = ($urandom_range(0, 3) != 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) rif.wb_rid_i = 4'(q[$urandom_range(0, q.size() - 1)]);
            else rif.wb_rid_i = 4'($urandom);
            rif.wb_res_i   = {$urandom, $urandom};
            rif.wb_cause_i = ($urandom_range(0, 23) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            rif.flush_i    = (q.size() > 0) && ($urandom_range(0, 31) == 0);
            rif.flush_rid_i = (q.size() > 0) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'd0;
            tick();
            n_chk++;
            if (rif.cmt_v_o !== e_v) begin
                n_fail++; $display("FAIL rnd_cmt_v cyc=%0d got %b want %b", c, rif.cmt_v_o, e_v);
            end
            for (int k = 0; k < 2; k++) if (e_v[k]) begin
                n_chk++;
                if (rif.cmt_Rt_o[k] !== e_Rt[k] || rif.cmt_res_o[k] !== e_res[k]) begin
                    n_fail++; $display("FAIL rnd_lane%0d cyc=%0d got Rt=%0d res=%h want Rt=%0d res=%h",
                        k, c, rif.cmt_Rt_o[k], rif.cmt_res_o[k], e_Rt[k], e_res[k]);
                end
            end
            n_chk++;
            if ({rif.exc_o, rif.exc_cause_o, rif.exc_rid_o} !== {e_exc, e_cause, e_rid}) begin
                n_fail++; $display("FAIL rnd_exc cyc=%0d got %b/%h/%0d want %b/%h/%0d",
                    c, rif.exc_o, rif.exc_cause_o, rif.exc_rid_o, e_exc, e_cause, e_rid);
            end
            n_chk++;
            if ({rif.empty_o, rif.full_o, rif.alloc_rdy_o, rif.alloc_rid_o} !==
                {q.size() == 0, q.size() == 16, q.size() != 16, 4'(mtail)}) begin
                n_fail++; $display("FAIL rnd_status cyc=%0d got e=%b f=%b r=%b rid=%0d want size=%0d rid=%0d",
                    c, rif.empty_o, rif.full_o, rif.alloc_rdy_o, rif.alloc_rid_o, q.size(), mtail);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_inorder();
        test_fill_wrap();
        test_exception();
        test_flush();
        test_reset_mid();
        test_ncmt1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
